// File: rtl/child_pkg.sv
// rtl/child_pkg.sv - shared sizing helpers for the child_fifo leaf
//
// Purpose: constant functions that size the child_fifo pointers and
//          occupancy counter, plus the DEPTH legality predicate used by the
//          elaboration-time check in the top level.
// Ports:   none (package)
package child_pkg;

  // Read/write pointer width; pointers wrap naturally at DEPTH.
  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

  // Occupancy counter width; one extra bit so LEVEL can represent DEPTH.
  function automatic int level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Natural pointer wrap only works for a power-of-two depth of at least 2.
  function automatic bit depth_ok(input int depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/child_fifo_mem.sv
// rtl/child_fifo_mem.sv - DEPTH x WIDTH storage array for child_fifo
//
// Purpose: register-array storage with one synchronous write port and one
//          asynchronous read port. Storage is deliberately not reset; the
//          top level masks the output whenever the queue is empty.
// Ports:
//   clk    in   1      write clock
//   we     in   1      write enable
//   waddr  in   AW     write address
//   wdata  in   WIDTH  write data
//   raddr  in   AW     read address
//   rdata  out  WIDTH  read data (combinational from raddr)
module child_fifo_mem
  import child_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4,
  parameter int AW    = ptr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/child_fifo.sv
// rtl/child_fifo.sv - parametrised first-word-fall-through FIFO leaf cell
//
// Purpose: carries WIDTH-bit data from I to O through a DEPTH-entry FWFT
//          queue with valid/ready handshakes on both sides.
// Ports:
//   clk      in   1       rising-edge clock
//   rst      in   1       asynchronous active-high reset
//   I        in   WIDTH   write data
//   I_VALID  in   1       write request
//   I_READY  out  1       space available (LEVEL != DEPTH)
//   O        out  WIDTH   head-of-queue data, 0 while empty
//   O_VALID  out  1       queue non-empty (LEVEL != 0)
//   O_READY  in   1       consumer accepts head
//   FLUSH    in   1       synchronous clear of pointers and LEVEL
//   LEVEL    out  LW      occupancy 0..DEPTH
module child_fifo
  import child_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4,
  parameter int PW    = ptr_width(DEPTH),
  parameter int LW    = level_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] I,
  input  logic             I_VALID,
  output logic             I_READY,
  output logic [WIDTH-1:0] O,
  output logic             O_VALID,
  input  logic             O_READY,
  input  logic             FLUSH,
  output logic [LW-1:0]    LEVEL
);

  if (!depth_ok(DEPTH)) begin : g_bad_depth
    $fatal(1, "child_fifo: DEPTH must be a power of two >= 2");
  end

  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [LW-1:0]    level;
  logic [WIDTH-1:0] rdata;
  logic             push;
  logic             pop;

  // Flags come only from the registered counter, so neither ready nor valid
  // has a combinational path from the opposite handshake input.
  assign I_READY = (level != FULL_LEVEL);
  assign O_VALID = (level != '0);
  assign push    = I_VALID & I_READY;
  assign pop     = O_VALID & O_READY;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (FLUSH) begin
      // Any transfer in the flush cycle is dropped; storage is left stale.
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        level <= level + 1'b1;
      end else if (pop && !push) begin
        level <= level - 1'b1;
      end
    end
  end

  child_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_mem (
    .clk   (clk),
    .we    (push & ~FLUSH),
    .waddr (wr_ptr),
    .wdata (I),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  // Stale storage is never visible: the head is forced to 0 while empty.
  assign O     = O_VALID ? rdata : '0;
  assign LEVEL = level;

endmodule

// File: tb/tb_child_fifo.sv
// tb/tb_child_fifo.sv - self-checking bench for child_fifo
module tb_child_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] I = '0;
  logic       I_VALID = 1'b0;
  logic       I_READY;
  logic [7:0] O;
  logic       O_VALID;
  logic       O_READY = 1'b0;
  logic       FLUSH = 1'b0;
  logic [2:0] LEVEL;

  int checks = 0;
  int failures = 0;

  // Reference model: the queue contents in order, oldest first.
  logic [7:0] model[$];

  child_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .I       (I),
    .I_VALID (I_VALID),
    .I_READY (I_READY),
    .O       (O),
    .O_VALID (O_VALID),
    .O_READY (O_READY),
    .FLUSH   (FLUSH),
    .LEVEL   (LEVEL)
  );

  always #5 clk = ~clk;

  // Drive one cycle of stimulus, advance the model at the edge, and return
  // 1 time unit after the edge with inputs back to idle.
  task automatic step(input logic iv, input logic [7:0] d, input logic ordy, input logic fl);
    logic do_push;
    logic do_pop;
    I_VALID = iv;
    I       = d;
    O_READY = ordy;
    FLUSH   = fl;
    do_push = iv && (model.size() < DEPTH);
    do_pop  = ordy && (model.size() > 0);
    @(posedge clk);
    if (fl) begin
      model.delete();
    end else begin
      if (do_pop)  void'(model.pop_front());
      if (do_push) model.push_back(d);
    end
    #1;
    I_VALID = 1'b0;
    O_READY = 1'b0;
    FLUSH   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    checks++; if (LEVEL !== 3'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", LEVEL); end
    checks++; if (O_VALID !== 1'b0) begin failures++; $display("FAIL reset_ovalid got=%b exp=0", O_VALID); end
    checks++; if (O !== 8'h00) begin failures++; $display("FAIL reset_o got=%0h exp=0", O); end
    checks++; if (I_READY !== 1'b1) begin failures++; $display("FAIL reset_iready got=%b exp=1", I_READY); end
    @(posedge clk); #3;
    rst = 1'b0;
    model.delete();
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
    checks++; if (LEVEL !== 3'd0 || O_VALID !== 1'b0 || I_READY !== 1'b1 || O !== 8'h00) begin
      failures++; $display("FAIL idle_state got lvl=%0d ov=%b ir=%b o=%0h exp lvl=0 ov=0 ir=1 o=0", LEVEL, O_VALID, I_READY, O);
    end
  endtask

  task automatic test_fill_drain();
    logic [7:0] vals [4];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, vals[i], 1'b0, 1'b0);
      checks++; if (LEVEL !== 3'(i + 1)) begin failures++; $display("FAIL fill_level got=%0d exp=%0d", LEVEL, i + 1); end
    end
    checks++; if (I_READY !== 1'b0) begin failures++; $display("FAIL full_iready got=%b exp=0", I_READY); end
    step(1'b1, 8'h55, 1'b0, 1'b0);
    checks++; if (LEVEL !== 3'd4) begin failures++; $display("FAIL overflow_level got=%0d exp=4", LEVEL); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (O_VALID !== 1'b1 || O !== vals[i]) begin
        failures++; $display("FAIL drain_data got ov=%b o=%0h exp ov=1 o=%0h", O_VALID, O, vals[i]);
      end
      step(1'b0, 8'h00, 1'b1, 1'b0);
    end
    checks++; if (O_VALID !== 1'b0 || LEVEL !== 3'd0 || O !== 8'h00) begin
      failures++; $display("FAIL drain_empty got ov=%b lvl=%0d o=%0h exp ov=0 lvl=0 o=0", O_VALID, LEVEL, O);
    end
  endtask

  task automatic test_latency();
    I_VALID = 1'b1;
    I = 8'hA5;
    #2;
    checks++; if (O_VALID !== 1'b0 || O !== 8'h00) begin
      failures++; $display("FAIL no_bypass got ov=%b o=%0h exp ov=0 o=0", O_VALID, O);
    end
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    checks++; if (O_VALID !== 1'b1 || O !== 8'hA5) begin
      failures++; $display("FAIL push_latency got ov=%b o=%0h exp ov=1 o=a5", O_VALID, O);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    checks++; if (LEVEL !== 3'd0) begin failures++; $display("FAIL latency_drain got=%0d exp=0", LEVEL); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] expect_head;
    step(1'b1, 8'd0, 1'b0, 1'b0);
    step(1'b1, 8'd1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      expect_head = 8'(i);
      checks++; if (LEVEL !== 3'd2 || O !== expect_head || O_VALID !== 1'b1) begin
        failures++; $display("FAIL b2b_stream got lvl=%0d o=%0h exp lvl=2 o=%0h", LEVEL, O, expect_head);
      end
      step(1'b1, 8'(i + 2), 1'b1, 1'b0);
    end
    for (int i = 20; i < 22; i++) begin
      checks++; if (O !== 8'(i)) begin failures++; $display("FAIL b2b_tail got=%0h exp=%0h", O, 8'(i)); end
      step(1'b0, 8'h00, 1'b1, 1'b0);
    end
    checks++; if (LEVEL !== 3'd0) begin failures++; $display("FAIL b2b_empty got=%0d exp=0", LEVEL); end
  endtask

  task automatic test_full_pop();
    for (int i = 0; i < 4; i++) step(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0);
    step(1'b1, 8'hEE, 1'b1, 1'b0);
    checks++; if (LEVEL !== 3'd3 || I_READY !== 1'b1) begin
      failures++; $display("FAIL full_pop got lvl=%0d ir=%b exp lvl=3 ir=1", LEVEL, I_READY);
    end
    for (int i = 1; i < 4; i++) begin
      checks++; if (O !== 8'hC0 + 8'(i)) begin failures++; $display("FAIL full_pop_data got=%0h exp=%0h", O, 8'hC0 + 8'(i)); end
      step(1'b0, 8'h00, 1'b1, 1'b0);
    end
    checks++; if (O_VALID !== 1'b0) begin failures++; $display("FAIL full_pop_empty got=%b exp=0", O_VALID); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) step(1'b1, 8'h60 + 8'(i), 1'b0, 1'b0);
    step(1'b1, 8'h77, 1'b1, 1'b1);
    checks++; if (LEVEL !== 3'd0 || O_VALID !== 1'b0 || O !== 8'h00) begin
      failures++; $display("FAIL flush got lvl=%0d ov=%b o=%0h exp lvl=0 ov=0 o=0", LEVEL, O_VALID, O);
    end
    step(1'b1, 8'h99, 1'b0, 1'b0);
    checks++; if (LEVEL !== 3'd1 || O !== 8'h99) begin
      failures++; $display("FAIL flush_repush got lvl=%0d o=%0h exp lvl=1 o=99", LEVEL, O);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    checks++; if (O_VALID !== 1'b0) begin failures++; $display("FAIL flush_sole got ov=%b exp=0", O_VALID); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 8'h30 + 8'(i), 1'b0, 1'b0);
    checks++; if (LEVEL !== 3'd3) begin failures++; $display("FAIL pre_reset_level got=%0d exp=3", LEVEL); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (LEVEL !== 3'd0 || O_VALID !== 1'b0 || O !== 8'h00 || I_READY !== 1'b1) begin
      failures++; $display("FAIL async_reset got lvl=%0d ov=%b o=%0h ir=%b exp lvl=0 ov=0 o=0 ir=1", LEVEL, O_VALID, O, I_READY);
    end
    model.delete();
    @(posedge clk); #3;
    rst = 1'b0;
    step(1'b0, 8'h00, 1'b0, 1'b0);
    checks++; if (LEVEL !== 3'd0) begin failures++; $display("FAIL post_reset_level got=%0d exp=0", LEVEL); end
  endtask

  task automatic test_random();
    logic [7:0] exp_o;
    for (int n = 0; n < 400; n++) begin
      step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 31) == 0));
      exp_o = (model.size() > 0) ? model[0] : 8'h00;
      checks++; if (LEVEL !== 3'(model.size()) || O_VALID !== (model.size() > 0) ||
                    I_READY !== (model.size() < DEPTH) || O !== exp_o) begin
        failures++;
        $display("FAIL random cyc=%0d got lvl=%0d ov=%b ir=%b o=%0h exp lvl=%0d o=%0h",
                 n, LEVEL, O_VALID, I_READY, O, model.size(), exp_o);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_latency();
    test_back_to_back();
    test_full_pop();
    test_flush();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
